// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI-Lite channel bundle between the uncached data port and the bus
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/holy_posted_uncached.sv
// holy_posted_uncached: uncached data port with posted-write buffer and strictly ordered loads over AXI-Lite
module holy_posted_uncached #(
    parameter int WB_DEPTH      = 4,
    parameter bit PARALLEL_AW_W = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               address,
    input  logic [31:0]               write_data,
    input  logic [3:0]                byte_enable,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    output logic [31:0]               read_data,
    output logic                      read_valid,
    input  logic                      read_ack,
    axi_lite_if.master                axi_lite,
    output logic [$clog2(WB_DEPTH):0] wb_count,
    output logic                      bus_error,
    output logic [31:0]               error_addr,
    input  logic                      error_clear
);
    localparam int AW = $clog2(WB_DEPTH);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, READ_OK} state_t;
    state_t state, state_d;
    logic [31:0] wb_addr [WB_DEPTH];
    logic [31:0] wb_data [WB_DEPTH];
    logic [3:0]  wb_strb [WB_DEPTH];
    logic [AW-1:0] head, tail;
    logic [31:0] rd_addr;
    logic rd_pend, aw_done, w_done;
    logic push, rd_take, pop, aw_hs, w_hs, r_hs, err_set;
    assign read_valid = state == READ_OK;
    assign req_ready = !rd_pend && !read_valid && (wb_count < (AW+1)'(WB_DEPTH));
    assign push = req_valid && req_ready && req_write;
    assign rd_take = req_valid && req_ready && !req_write;
    assign aw_hs = axi_lite.awvalid && axi_lite.awready;
    assign w_hs = axi_lite.wvalid && axi_lite.wready;
    assign r_hs = state == RD_DATA && axi_lite.rvalid;
    assign pop = state == WR_RESP && axi_lite.bvalid;
    assign err_set = (pop && axi_lite.bresp != 2'b00) || (r_hs && axi_lite.rresp != 2'b00);
    assign axi_lite.awaddr = {wb_addr[head][31:2], 2'b00};
    assign axi_lite.wdata = wb_data[head];
    assign axi_lite.wstrb = wb_strb[head];
    assign axi_lite.araddr = rd_addr;
    // A push in IDLE starts the write next cycle; the entry is already registered by then.
    always_comb begin
        state_d = state;
        axi_lite.awvalid = 1'b0;
        axi_lite.wvalid = 1'b0;
        axi_lite.bready = 1'b0;
        axi_lite.arvalid = 1'b0;
        axi_lite.rready = 1'b0;
        case (state)
            IDLE: state_d = (|wb_count || push) ? WR_ADDR : (rd_pend || rd_take) ? RD_ADDR : IDLE;
            WR_ADDR: begin
                axi_lite.awvalid = !aw_done;
                axi_lite.wvalid = PARALLEL_AW_W && !w_done;
                state_d = !PARALLEL_AW_W ? (axi_lite.awready ? WR_DATA : WR_ADDR) :
                          ((aw_done || axi_lite.awready) && (w_done || axi_lite.wready)) ? WR_RESP : WR_ADDR;
            end
            WR_DATA: begin
                axi_lite.wvalid = 1'b1;
                state_d = axi_lite.wready ? WR_RESP : WR_DATA;
            end
            WR_RESP: begin
                axi_lite.bready = 1'b1;
                state_d = axi_lite.bvalid ? IDLE : WR_RESP;
            end
            RD_ADDR: begin
                axi_lite.arvalid = 1'b1;
                state_d = axi_lite.arready ? RD_DATA : RD_ADDR;
            end
            RD_DATA: begin
                axi_lite.rready = 1'b1;
                state_d = axi_lite.rvalid ? READ_OK : RD_DATA;
            end
            READ_OK: state_d = read_ack ? IDLE : READ_OK;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            wb_count <= '0;
            rd_pend <= 1'b0;
            rd_addr <= '0;
            read_data <= '0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            bus_error <= 1'b0;
            error_addr <= '0;
        end else begin
            state <= state_d;
            aw_done <= state == WR_ADDR && state_d == WR_ADDR && (aw_done || aw_hs);
            w_done <= state == WR_ADDR && state_d == WR_ADDR && (w_done || w_hs);
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            wb_count <= wb_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (rd_take) begin
                rd_pend <= 1'b1;
                rd_addr <= address;
            end else if (r_hs) begin
                rd_pend <= 1'b0;
            end
            if (r_hs) read_data <= axi_lite.rdata;
            // A clear in the same cycle as a new error wins and the error is dropped.
            if (error_clear) begin
                bus_error <= 1'b0;
                error_addr <= '0;
            end else if (err_set && !bus_error) begin
                bus_error <= 1'b1;
                error_addr <= r_hs ? rd_addr : wb_addr[head];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[tail] <= address;
            wb_data[tail] <= write_data;
            wb_strb[tail] <= byte_enable;
        end
    end
endmodule
